// File: rtl/alu_pkg.sv
// Shared opcode encoding, sequencer states and opcode width for the queued ALU.
package alu_pkg;
  localparam int OPCODE_WIDTH = 8;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ADD          = 8'h00,
    OP_SUB          = 8'h01,
    OP_MULT         = 8'h02,
    OP_DIVIDE       = 8'h03,
    OP_MFHI         = 8'h04,
    OP_MFLO         = 8'h05,
    OP_AND          = 8'h06,
    OP_OR           = 8'h07,
    OP_XOR          = 8'h08,
    OP_LESS_THAN    = 8'h09,
    OP_ROTATE_LEFT  = 8'h0A,
    OP_ROTATE_RIGHT = 8'h0B
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } alu_state_e;
endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative W-step shift-add multiplier / restoring divider sharing one HI/LO register pair.
module alu_muldiv_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic          div_q, div_d, busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    add_sum, rem_sh;
  logic [W-1:0]  step_hi, step_lo;

  // One iteration: multiply keeps the multiplier in LO and shifts the product in from the top;
  // divide shifts the dividend out of LO into the remainder and shifts quotient bits in.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {hi_q, lo_q[W-1]};
    if (div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        step_hi = W'(rem_sh - {1'b0, opnd_q});
        step_lo = {lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[W-1:0];
        step_lo = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      step_hi = add_sum[W:1];
      step_lo = {add_sum[0], lo_q[W-1:1]};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = is_div ? a : b;
      opnd_d = is_div ? b : a;
      div_d  = is_div;
      busy_d = 1'b1;
      cnt_d  = CW'(W);
    end else if (busy_q) begin
      hi_d   = step_hi;
      lo_d   = step_lo;
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Final-step values are presented combinationally so the caller can capture them on the same edge.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign hi   = step_hi;
  assign lo   = step_lo;
endmodule

// File: rtl/alu_queue_top.sv
// Instruction FIFO feeding a pop/execute/hold sequencer with HI/LO state and a sequential mul/div unit.
module alu_queue_top
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 8,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             instValid,
  output logic                             instReady,
  input  logic [OPCODE_WIDTH-1:0]          opcode,
  input  logic [OPERAND_WIDTH-1:0]         operandA,
  input  logic [OPERAND_WIDTH-1:0]         operandB,
  output logic                             resultValid,
  input  logic                             resultReady,
  output logic [OPERAND_WIDTH-1:0]         result,
  output logic                             error,
  output logic                             zero,
  output logic                             carry,
  output logic                             overflow,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queueCount
);
  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op;
    logic [W-1:0]            a;
    logic [W-1:0]            b;
  } inst_t;

  inst_t         mem_q [QUEUE_DEPTH];
  inst_t         head, inst_q, inst_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, push, pop, full, empty;
  alu_state_e    state_q, state_d;
  logic          md_q, md_d, is_md_head, md_is_div, md_start, md_busy, md_done;
  logic [W-1:0]  md_hi, md_lo;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic          vld_q, vld_d, err_q, err_d, zero_q, zero_d, cry_q, cry_d, ovf_q, ovf_d;
  logic [W:0]    add_w, sub_w;
  logic [W-1:0]  rot_sh, rot_res, sc_res;
  logic          sc_err, sc_cry, sc_ovf;

  // rdy_q keeps instReady low through reset and raises it on the first edge afterwards.
  assign head      = mem_q[rd_ptr_q];
  assign full      = (cnt_q == CW'(QUEUE_DEPTH));
  assign empty     = (cnt_q == '0);
  assign instReady = rdy_q && !full;
  assign push      = instValid && instReady;
  assign pop       = (state_q == ST_IDLE) && !empty;

  // Divide by zero never enters the iterative unit; it resolves in one EXEC cycle as an error.
  assign md_is_div  = (head.op == OP_DIVIDE);
  assign is_md_head = (head.op == OP_MULT) || (md_is_div && head.b != '0);
  assign md_start   = pop && is_md_head && !md_busy;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {opcode, operandA, operandB};
  end

  always_comb begin
    add_w   = {1'b0, inst_q.a} + {1'b0, inst_q.b};
    sub_w   = {1'b0, inst_q.a} - {1'b0, inst_q.b};
    // Right rotate by b is a left rotate by W-b; both take the upper half of the doubled word.
    rot_sh  = (inst_q.op == OP_ROTATE_LEFT) ? inst_q.b : W'(W) - inst_q.b;
    rot_res = W'(({inst_q.a, inst_q.a} << rot_sh) >> W);
    sc_res  = '0;
    sc_err  = 1'b0;
    sc_cry  = 1'b0;
    sc_ovf  = 1'b0;
    case (inst_q.op)
      OP_ADD: begin
        sc_res = add_w[W-1:0];
        sc_cry = add_w[W];
        sc_ovf = (inst_q.a[W-1] == inst_q.b[W-1]) && (add_w[W-1] != inst_q.a[W-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[W-1:0];
        sc_cry = sub_w[W];
        sc_ovf = (inst_q.a[W-1] != inst_q.b[W-1]) && (sub_w[W-1] != inst_q.a[W-1]);
      end
      OP_MFHI:      sc_res = hi_q;
      OP_MFLO:      sc_res = lo_q;
      OP_AND:       sc_res = inst_q.a & inst_q.b;
      OP_OR:        sc_res = inst_q.a | inst_q.b;
      OP_XOR:       sc_res = inst_q.a ^ inst_q.b;
      OP_LESS_THAN: sc_res = {{(W-1){1'b0}}, (inst_q.a < inst_q.b)};
      OP_ROTATE_LEFT, OP_ROTATE_RIGHT: begin
        if (32'(inst_q.b) >= W) sc_err = 1'b1;
        else                    sc_res = rot_res;
      end
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    md_d    = md_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    vld_d   = vld_q;
    err_d   = err_q;
    zero_d  = zero_q;
    cry_d   = cry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          inst_d  = head;
          md_d    = is_md_head;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (md_q) begin
          if (md_done) begin
            hi_d    = md_hi;
            lo_d    = md_lo;
            res_d   = md_lo;
            err_d   = 1'b0;
            cry_d   = 1'b0;
            ovf_d   = (inst_q.op == OP_MULT) && (md_hi != '0);
            zero_d  = (md_lo == '0);
            vld_d   = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          res_d   = sc_res;
          err_d   = sc_err;
          cry_d   = sc_cry;
          ovf_d   = sc_ovf;
          zero_d  = (sc_res == '0);
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resultReady) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      state_q  <= ST_IDLE;
      inst_q   <= '0;
      md_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      cry_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= 1'b1;
      state_q  <= state_d;
      inst_q   <= inst_d;
      md_q     <= md_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      cry_q    <= cry_d;
      ovf_q    <= ovf_d;
    end
  end

  alu_muldiv_seq #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rstN),
    .start  (md_start),
    .is_div (md_is_div),
    .a      (head.a),
    .b      (head.b),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  assign resultValid = vld_q;
  assign result      = res_q;
  assign error       = err_q;
  assign zero        = zero_q;
  assign carry       = cry_q;
  assign overflow    = ovf_q;
  assign queueCount  = cnt_q;
endmodule

// File: tb/tb_alu_queue_top.sv
// Directed self-checking bench for alu_queue_top at W=8, DEPTH=4.
module tb_alu_queue_top;
  logic       clk, rstN, instValid, instReady, resultValid, resultReady;
  logic [7:0] opcode, operandA, operandB, result;
  logic       error, zero, carry, overflow;
  logic [2:0] queueCount;
  int         chk = 0;
  int         err = 0;

  alu_queue_top #(.OPERAND_WIDTH(8), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rstN(rstN), .instValid(instValid), .instReady(instReady), .opcode(opcode),
    .operandA(operandA), .operandB(operandB), .resultValid(resultValid), .resultReady(resultReady),
    .result(result), .error(error), .zero(zero), .carry(carry), .overflow(overflow),
    .queueCount(queueCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    instValid = 1'b1; opcode = op; operandA = a; operandB = b;
    while (!instReady && n < 50) begin tick(); n++; end
    if (!instReady) begin chk++; err++; $display("FAIL push_timeout: instReady stayed 0"); end
    tick();
    instValid = 1'b0;
  endtask

  // Push one instruction, wait for its result, record latency in edges after the push edge, handshake.
  task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [3:0] f, output int lat);
    lat = 0;
    push(op, a, b);
    while (!resultValid && lat < 60) begin tick(); lat++; end
    if (!resultValid) begin chk++; err++; $display("FAIL result_timeout: op %h got no result", op); end
    r = result;
    f = {error, zero, carry, overflow};
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b1; instValid = 1'b0; resultReady = 1'b0;
    opcode = '0; operandA = '0; operandB = '0;
    #3 rstN = 1'b0;
    #1;
    chk++; if (instReady !== 1'b0) begin err++; $display("FAIL reset_ready got %b want 0", instReady); end
    chk++; if ({resultValid, result, error, zero, carry, overflow} !== '0) begin err++; $display("FAIL reset_outputs got %b want 0", {resultValid, result, error, zero, carry, overflow}); end
    chk++; if (queueCount !== 3'd0) begin err++; $display("FAIL reset_count got %0d want 0", queueCount); end
    tick(); tick();
    chk++; if (instReady !== 1'b0) begin err++; $display("FAIL reset_ready_held got %b want 0", instReady); end
    rstN = 1'b1;
    tick();
    chk++; if (instReady !== 1'b1) begin err++; $display("FAIL ready_after_reset got %b want 1", instReady); end
  endtask

  task automatic test_add();
    logic [7:0] r; logic [3:0] f; int lat;
    push(8'h00, 8'hC8, 8'h64);
    chk++; if (queueCount !== 3'd1) begin err++; $display("FAIL add_count got %0d want 1", queueCount); end
    tick();
    chk++; if (resultValid !== 1'b0) begin err++; $display("FAIL add_early got %b want 0", resultValid); end
    tick();
    chk++; if (resultValid !== 1'b1) begin err++; $display("FAIL add_latency got %b want 1", resultValid); end
    chk++; if (result !== 8'h2C) begin err++; $display("FAIL add_result got %h want 2c", result); end
    chk++; if ({error, zero, carry, overflow} !== 4'b0010) begin err++; $display("FAIL add_flags got %b want 0010", {error, zero, carry, overflow}); end
    resultReady = 1'b1; tick(); resultReady = 1'b0;
    run_op(8'h00, 8'hFF, 8'h01, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b0110}) begin err++; $display("FAIL add_wrap got %h/%b want 00/0110", r, f); end
    run_op(8'h00, 8'h7F, 8'h01, r, f, lat);
    chk++; if ({r, f} !== {8'h80, 4'b0001}) begin err++; $display("FAIL add_ovf got %h/%b want 80/0001", r, f); end
    run_op(8'h01, 8'h05, 8'h07, r, f, lat);
    chk++; if ({r, f} !== {8'hFE, 4'b0010}) begin err++; $display("FAIL sub_borrow got %h/%b want fe/0010", r, f); end
    run_op(8'h01, 8'h80, 8'h01, r, f, lat);
    chk++; if ({r, f} !== {8'h7F, 4'b0001}) begin err++; $display("FAIL sub_ovf got %h/%b want 7f/0001", r, f); end
  endtask

  task automatic test_logic();
    logic [7:0] r; logic [3:0] f; int lat;
    run_op(8'h06, 8'hF0, 8'h3C, r, f, lat);
    chk++; if ({r, f} !== {8'h30, 4'b0000}) begin err++; $display("FAIL and got %h/%b want 30/0000", r, f); end
    run_op(8'h07, 8'hF0, 8'h0C, r, f, lat);
    chk++; if (r !== 8'hFC) begin err++; $display("FAIL or got %h want fc", r); end
    run_op(8'h08, 8'h5A, 8'h5A, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b0100}) begin err++; $display("FAIL xor got %h/%b want 00/0100", r, f); end
    run_op(8'h09, 8'h03, 8'h05, r, f, lat);
    chk++; if (r !== 8'h01) begin err++; $display("FAIL lt_true got %h want 01", r); end
    run_op(8'h09, 8'h05, 8'h03, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b0100}) begin err++; $display("FAIL lt_false got %h/%b want 00/0100", r, f); end
  endtask

  task automatic test_mult();
    logic [7:0] r; logic [3:0] f; int lat;
    run_op(8'h02, 8'hFF, 8'hFF, r, f, lat);
    chk++; if (lat !== 9) begin err++; $display("FAIL mult_latency got %0d want 9", lat); end
    chk++; if ({r, f} !== {8'h01, 4'b0001}) begin err++; $display("FAIL mult got %h/%b want 01/0001", r, f); end
    run_op(8'h04, 8'h00, 8'h00, r, f, lat);
    chk++; if (r !== 8'hFE) begin err++; $display("FAIL mfhi_mult got %h want fe", r); end
    run_op(8'h05, 8'h12, 8'h34, r, f, lat);
    chk++; if (r !== 8'h01) begin err++; $display("FAIL mflo_mult got %h want 01", r); end
    run_op(8'h02, 8'h0D, 8'h0B, r, f, lat);
    chk++; if ({r, f} !== {8'h8F, 4'b0000}) begin err++; $display("FAIL mult_small got %h/%b want 8f/0000", r, f); end
  endtask

  task automatic test_div();
    logic [7:0] r; logic [3:0] f; int lat;
    run_op(8'h03, 8'hC8, 8'h07, r, f, lat);
    chk++; if (lat !== 9) begin err++; $display("FAIL div_latency got %0d want 9", lat); end
    chk++; if ({r, f} !== {8'h1C, 4'b0000}) begin err++; $display("FAIL div got %h/%b want 1c/0000", r, f); end
    run_op(8'h04, 8'h00, 8'h00, r, f, lat);
    chk++; if (r !== 8'h04) begin err++; $display("FAIL mfhi_div got %h want 04", r); end
    run_op(8'h03, 8'h10, 8'h00, r, f, lat);
    chk++; if (lat !== 2) begin err++; $display("FAIL div0_latency got %0d want 2", lat); end
    chk++; if ({r, f} !== {8'h00, 4'b1100}) begin err++; $display("FAIL div0 got %h/%b want 00/1100", r, f); end
    run_op(8'h05, 8'h00, 8'h00, r, f, lat);
    chk++; if (r !== 8'h1C) begin err++; $display("FAIL mflo_after_div0 got %h want 1c", r); end
  endtask

  task automatic test_rotate();
    logic [7:0] r; logic [3:0] f; int lat;
    run_op(8'h0A, 8'h81, 8'h01, r, f, lat);
    chk++; if ({r, f} !== {8'h03, 4'b0000}) begin err++; $display("FAIL rotl1 got %h/%b want 03/0000", r, f); end
    run_op(8'h0A, 8'h81, 8'h07, r, f, lat);
    chk++; if (r !== 8'hC0) begin err++; $display("FAIL rotl7 got %h want c0", r); end
    run_op(8'h0B, 8'h81, 8'h01, r, f, lat);
    chk++; if (r !== 8'hC0) begin err++; $display("FAIL rotr1 got %h want c0", r); end
    run_op(8'h0B, 8'h81, 8'h00, r, f, lat);
    chk++; if (r !== 8'h81) begin err++; $display("FAIL rotr0 got %h want 81", r); end
    run_op(8'h0A, 8'h81, 8'd8, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b1100}) begin err++; $display("FAIL rotl8 got %h/%b want 00/1100", r, f); end
    run_op(8'h0A, 8'h81, 8'd205, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b1100}) begin err++; $display("FAIL rotl205 got %h/%b want 00/1100", r, f); end
    run_op(8'hFF, 8'h12, 8'h34, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b1100}) begin err++; $display("FAIL bad_opcode got %h/%b want 00/1100", r, f); end
    run_op(8'h05, 8'h00, 8'h00, r, f, lat);
    chk++; if (r !== 8'h1C) begin err++; $display("FAIL lo_after_invalid got %h want 1c", r); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int n;
    for (int i = 0; i < 6; i++) begin
      instValid = 1'b1; opcode = 8'h00; operandA = 8'(i + 1); operandB = 8'h10;
      if (instReady) acc++;
      tick();
    end
    instValid = 1'b0;
    chk++; if (acc !== 5) begin err++; $display("FAIL b2b_accepted got %0d want 5", acc); end
    chk++; if (instReady !== 1'b0) begin err++; $display("FAIL b2b_full_ready got %b want 0", instReady); end
    chk++; if (queueCount !== 3'd4) begin err++; $display("FAIL b2b_count got %0d want 4", queueCount); end
    tick(); tick();
    chk++; if ({resultValid, result} !== {1'b1, 8'h11}) begin err++; $display("FAIL b2b_hold got %b/%h want 1/11", resultValid, result); end
    resultReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!resultValid && n < 20) begin tick(); n++; end
      chk++; if ({resultValid, result} !== {1'b1, 8'(8'h11 + k)}) begin err++; $display("FAIL b2b_order%0d got %b/%h want 1/%h", k, resultValid, result, 8'(8'h11 + k)); end
      tick();
    end
    resultReady = 1'b0;
    tick(); tick(); tick();
    chk++; if ({resultValid, queueCount} !== 4'b0000) begin err++; $display("FAIL b2b_drained got %b/%0d want 0/0", resultValid, queueCount); end
  endtask

  task automatic test_reset_mid_mult();
    logic [7:0] r; logic [3:0] f; int lat;
    logic seen = 1'b0;
    push(8'h02, 8'hFF, 8'hFF);
    tick(); tick(); tick(); tick();
    rstN = 1'b0;
    #1;
    chk++; if ({resultValid, result, error, zero, carry, overflow, instReady, queueCount} !== '0) begin
      err++; $display("FAIL mid_reset_outputs got %b want 0", {resultValid, result, error, zero, carry, overflow, instReady, queueCount});
    end
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (resultValid) seen = 1'b1;
    end
    chk++; if (seen !== 1'b0) begin err++; $display("FAIL mid_reset_result got %b want 0", seen); end
    run_op(8'h04, 8'h00, 8'h00, r, f, lat);
    chk++; if ({r, f} !== {8'h00, 4'b0100}) begin err++; $display("FAIL hi_after_reset got %h/%b want 00/0100", r, f); end
    run_op(8'h05, 8'h00, 8'h00, r, f, lat);
    chk++; if (r !== 8'h00) begin err++; $display("FAIL lo_after_reset got %h want 00", r); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_mult();
    test_div();
    test_rotate();
    test_back_to_back();
    test_reset_mid_mult();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule

// File: doc/alu_queue_top.md
ALU_QUEUE_TOP -- requirements
Module: alu_queue_top

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 8, operand/result width W; legal range 4..32.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, number of instruction queue entries; power of two, at least 2.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rstN  in  1  reset, asynchronous, active-low.
REQ-005 instValid  in  1  instruction offered.
REQ-006 instReady  out  1  queue can accept; equals not-full.
REQ-007 opcode  in  8  operation code, alu_pkg encoding.
REQ-008 operandA / operandB  in  W each  operands.
REQ-009 resultValid  out  1  result and flags valid.
REQ-010 resultReady  in  1  consumer accepts result.
REQ-011 result  out  W  operation result.
REQ-012 error / zero / carry / overflow  out  1 each  status flags, qualified by resultValid.
REQ-013 queueCount  out  $clog2(QUEUE_DEPTH+1)  entries currently queued.

Function
REQ-014 SHALL push {opcode,A,B} into the FIFO when instValid && instReady; one instruction per cycle, no multi-write loading.
REQ-015 SHALL run an FSM: IDLE -> (queue non-empty) pop -> EXEC -> DONE -> (resultReady) IDLE.
REQ-016 Single-cycle ops (ADD, SUB, MFHI, MFLO, AND, OR, XOR, LESS_THAN, ROTATE_LEFT, ROTATE_RIGHT, invalid): EXEC lasts 1 cycle; resultValid rises 2 cycles after the push edge into an empty, idle block.
REQ-017 MULT and DIVIDE SHALL be iterative: EXEC lasts exactly W cycles (shift-add multiply, restoring divide).
REQ-018 Opcodes: ADD=0x00 SUB=0x01 MULT=0x02 DIVIDE=0x03 MFHI=0x04 MFLO=0x05 AND=0x06 OR=0x07 XOR=0x08 LESS_THAN=0x09 ROTATE_LEFT=0x0A ROTATE_RIGHT=0x0B; any other value is invalid.
REQ-019 ADD: result = A+B mod 2^W; carry = carry-out; overflow = signed overflow.
REQ-020 SUB: result = A-B mod 2^W; carry = borrow (A<B unsigned); overflow = signed overflow.
REQ-021 MULT: {HI,LO} = A*B (2W bits); result = LO; overflow = (HI != 0); carry 0.
REQ-022 DIVIDE: LO = A/B, HI = A%B unsigned; result = quotient.
REQ-023 DIVIDE with B=0: error 1, result 0, HI/LO unchanged; EXEC lasts 1 cycle.
REQ-024 MFHI/MFLO: result = HI/LO; operands ignored.
REQ-025 LESS_THAN: result = 1 if A<B unsigned, else 0.
REQ-026 Rotates by B positions; B >= W SHALL give error 1, result 0.
REQ-027 Invalid opcode: error 1, result 0, no state change except the queue pop.
REQ-028 zero = (result == 0) for every op, including error cases; flags not defined for an op SHALL be 0.
REQ-029 result and flags SHALL be registered and held stable while resultValid && !resultReady.
REQ-030 A push while full SHALL be ignored; push and pop in the same cycle SHALL leave queueCount unchanged.
REQ-031 Next pop SHALL occur in the cycle after the DONE handshake; no result is ever dropped.

Reset
REQ-032 rstN low SHALL immediately clear: FSM to IDLE, FIFO pointers and queueCount to 0, HI/LO to 0, resultValid/result/flags to 0, instReady to 0.
REQ-033 instReady SHALL be 1 from the first clock edge after rstN deasserts; reset during EXEC SHALL abort the operation with no result.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode enum, the FSM state typedef and OPCODE_WIDTH=8.
REQ-035 The iterative multiply/divide datapath SHALL be sub-module alu_muldiv_seq (start, busy, done handshake), parametrised by W.

Verification (W=8, DEPTH=4)
REQ-036 ADD 0xC8,0x64 -> result 0x2C, carry 1, overflow 0, zero 0; resultValid 2 cycles after push.
REQ-037 MULT 0xFF,0xFF -> result 0x01, overflow 1 after 8 EXEC cycles; then MFHI -> 0xFE, MFLO -> 0x01.
REQ-038 DIVIDE 0xC8,0x07 -> 0x1C, then MFHI -> 0x04; DIVIDE 0x10,0x00 -> error 1, result 0, zero 1, and a following MFLO still returns 0x1C.
REQ-039 ROTATE_LEFT 0x81 by 1 -> 0x03; ROTATE_LEFT by 205 -> error 1; opcode 0xFF -> error 1.
REQ-040 resultReady held 0 while 6 ADDs are offered -> 5 accepted (1 in DONE, 4 queued), instReady 0 and queueCount 4; release -> 5 results returned in order.
REQ-041 rstN pulsed low mid-MULT -> all outputs 0 at once, no result produced, HI/LO read 0 after reset.
